// File: rtl/jtcop_snd_pkg.sv
// Shared types and constants for the JTCOP sound ROM arbiter.
package jtcop_snd_pkg;
  localparam int unsigned SDRAM_AW = 22;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT
  } arb_state_t;

  localparam logic ID_CPU = 1'b0;
  localparam logic ID_PCM = 1'b1;
endpackage

// File: rtl/jtcop_snd_romcache.sv
// One-word read cache for a byte-wide ROM requester sitting on a 16-bit SDRAM slot.
module jtcop_snd_romcache #(
  parameter int unsigned AW = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [AW-1:0] addr,
  input  logic          cs,
  input  logic          fill,
  input  logic          fill_valid,
  input  logic [AW-2:0] fill_tag,
  input  logic [15:0]   fill_data,
  output logic [7:0]    data,
  output logic          ok,
  output logic          miss
);
  logic [AW-2:0] tag;
  logic [15:0]   word;
  logic          valid;
  logic          hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      tag   <= '0;
      word  <= '0;
      valid <= 1'b0;
    end else begin
      if (fill) begin
        tag   <= fill_tag;
        word  <= fill_data;
        valid <= fill_valid;
      end
      // clear has priority over a fill landing in the same cycle
      if (clr) valid <= 1'b0;
    end
  end

  assign hit  = cs & valid & (tag == addr[AW-1:1]);
  assign ok   = hit;
  assign miss = cs & ~hit;
  assign data = addr[0] ? word[15:8] : word[7:0];
endmodule

// File: rtl/jtcop_snd_romarb.sv
// Arbitrates the sound CPU and ADPCM ROM caches onto a single SDRAM read slot.
module jtcop_snd_romarb
  import jtcop_snd_pkg::*;
#(
  parameter logic [SDRAM_AW-1:0] CPU_OFFSET = 22'h0,
  parameter logic [SDRAM_AW-1:0] PCM_OFFSET = 22'h0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                downloading,
  input  logic [14:0]         cpu_addr,
  input  logic                cpu_cs,
  output logic [7:0]          cpu_data,
  output logic                cpu_ok,
  input  logic [17:0]         pcm_addr,
  input  logic                pcm_cs,
  output logic [7:0]          pcm_data,
  output logic                pcm_ok,
  output logic [SDRAM_AW-1:0] sdram_addr,
  output logic                sdram_req,
  input  logic                sdram_ack,
  input  logic                sdram_dok,
  input  logic [15:0]         sdram_din
);
  arb_state_t          state;
  logic                sel;
  logic                last;
  logic                poison;
  logic [16:0]         tag_q;
  logic                cpu_miss, pcm_miss;
  logic                pick;
  logic [16:0]         pick_tag;
  logic [SDRAM_AW-1:0] pick_addr;
  logic                fill_cpu, fill_pcm, fill_valid;

  always_comb begin
    pick = ID_CPU;
    if (cpu_miss && pcm_miss) pick = ~last;
    else if (pcm_miss)        pick = ID_PCM;
    pick_tag  = (pick == ID_PCM) ? pcm_addr[17:1] : {3'b000, cpu_addr[14:1]};
    pick_addr = ((pick == ID_PCM) ? PCM_OFFSET : CPU_OFFSET) + {5'b00000, pick_tag};
  end

  assign fill_cpu   = (state == ST_WAIT) && sdram_dok && (sel == ID_CPU);
  assign fill_pcm   = (state == ST_WAIT) && sdram_dok && (sel == ID_PCM);
  // a fetch overlapped by a download at any point returns stale data
  assign fill_valid = ~poison & ~downloading;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      sel        <= ID_CPU;
      last       <= ID_CPU;
      tag_q      <= '0;
      poison     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!downloading && (cpu_miss || pcm_miss)) begin
            sel        <= pick;
            tag_q      <= pick_tag;
            sdram_addr <= pick_addr;
            sdram_req  <= 1'b1;
            poison     <= 1'b0;
            state      <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (downloading) poison <= 1'b1;
          if (sdram_ack) begin
            sdram_req <= 1'b0;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (downloading) poison <= 1'b1;
          if (sdram_dok) begin
            last  <= sel;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  jtcop_snd_romcache #(.AW(15)) u_cpu_cache (
    .clk        (clk),
    .rst        (rst),
    .clr        (downloading),
    .addr       (cpu_addr),
    .cs         (cpu_cs),
    .fill       (fill_cpu),
    .fill_valid (fill_valid),
    .fill_tag   (tag_q[13:0]),
    .fill_data  (sdram_din),
    .data       (cpu_data),
    .ok         (cpu_ok),
    .miss       (cpu_miss)
  );

  jtcop_snd_romcache #(.AW(18)) u_pcm_cache (
    .clk        (clk),
    .rst        (rst),
    .clr        (downloading),
    .addr       (pcm_addr),
    .cs         (pcm_cs),
    .fill       (fill_pcm),
    .fill_valid (fill_valid),
    .fill_tag   (tag_q),
    .fill_data  (sdram_din),
    .data       (pcm_data),
    .ok         (pcm_ok),
    .miss       (pcm_miss)
  );
endmodule

// File: tb/tb_jtcop_snd_romarb.sv
// Directed-vector bench for the sound ROM arbiter; PCM offset chosen to exercise wrap-around.
module tb_jtcop_snd_romarb;
  localparam logic [21:0] CPU_OFS = 22'h010000;
  localparam logic [21:0] PCM_OFS = 22'h3FFFF0;

  logic        clk = 1'b0;
  logic        rst, downloading;
  logic [14:0] cpu_addr;
  logic        cpu_cs;
  logic [7:0]  cpu_data;
  logic        cpu_ok;
  logic [17:0] pcm_addr;
  logic        pcm_cs;
  logic [7:0]  pcm_data;
  logic        pcm_ok;
  logic [21:0] sdram_addr;
  logic        sdram_req, sdram_ack, sdram_dok;
  logic [15:0] sdram_din;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  jtcop_snd_romarb #(.CPU_OFFSET(CPU_OFS), .PCM_OFFSET(PCM_OFS)) dut (
    .clk         (clk),
    .rst         (rst),
    .downloading (downloading),
    .cpu_addr    (cpu_addr),
    .cpu_cs      (cpu_cs),
    .cpu_data    (cpu_data),
    .cpu_ok      (cpu_ok),
    .pcm_addr    (pcm_addr),
    .pcm_cs      (pcm_cs),
    .pcm_data    (pcm_data),
    .pcm_ok      (pcm_ok),
    .sdram_addr  (sdram_addr),
    .sdram_req   (sdram_req),
    .sdram_ack   (sdram_ack),
    .sdram_dok   (sdram_dok),
    .sdram_din   (sdram_din)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_req();
    int t = 0;
    while (sdram_req !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("req_seen", {31'd0, sdram_req}, 32'd1);
  endtask

  task automatic do_ack(input int dly);
    repeat (dly) @(negedge clk);
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0;
    check("req_drop", {31'd0, sdram_req}, 32'd0);
  endtask

  task automatic do_dok(input logic [15:0] word);
    sdram_dok = 1'b1;
    sdram_din = word;
    @(negedge clk);
    sdram_dok = 1'b0;
    sdram_din = 16'hxxxx;
  endtask

  task automatic serve(input string tag, input logic [21:0] exp_addr,
                       input logic [15:0] word, input int dly);
    wait_req();
    check(tag, {10'd0, sdram_addr}, {10'd0, exp_addr});
    do_ack(dly);
    do_dok(word);
  endtask

  initial begin
    rst = 1'b1; downloading = 1'b0;
    cpu_addr = '0; cpu_cs = 1'b0; pcm_addr = '0; pcm_cs = 1'b0;
    sdram_ack = 1'b0; sdram_dok = 1'b0; sdram_din = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // reset state
    check("rst_cpu_ok",   {31'd0, cpu_ok},    32'd0);
    check("rst_pcm_ok",   {31'd0, pcm_ok},    32'd0);
    check("rst_cpu_data", {24'd0, cpu_data},  32'd0);
    check("rst_pcm_data", {24'd0, pcm_data},  32'd0);
    check("rst_req",      {31'd0, sdram_req}, 32'd0);
    check("rst_addr",     {10'd0, sdram_addr}, 32'd0);

    // cold miss on CPU
    cpu_cs = 1'b1; cpu_addr = 15'h0010;
    @(negedge clk);
    check("cold_ok_low", {31'd0, cpu_ok}, 32'd0);
    serve("cold_addr", CPU_OFS + 22'd8, 16'hBEEF, 2);
    check("cold_ok",   {31'd0, cpu_ok},   32'd1);
    check("cold_lo",   {24'd0, cpu_data}, 32'hEF);
    cpu_addr = 15'h0011;
    @(negedge clk);
    check("cold_hi",   {24'd0, cpu_data}, 32'hBE);
    check("cold_hi_ok", {31'd0, cpu_ok},  32'd1);
    repeat (2) @(negedge clk);
    check("cold_noreq", {31'd0, sdram_req}, 32'd0);

    // tie: last served is CPU, so PCM goes first; PCM address wraps
    cpu_addr = 15'h0020; pcm_cs = 1'b1; pcm_addr = 18'h00040;
    serve("tie1_pcm_addr", 22'h000010, 16'h1234, 1);
    check("tie1_pcm_ok",   {31'd0, pcm_ok},   32'd1);
    check("tie1_pcm_data", {24'd0, pcm_data}, 32'h34);
    check("tie1_cpu_wait", {31'd0, cpu_ok},   32'd0);
    check("idle_gap",      {31'd0, sdram_req}, 32'd0);
    @(negedge clk);
    check("b2b_req",       {31'd0, sdram_req}, 32'd1);
    serve("tie1_cpu_addr", CPU_OFS + 22'h10, 16'h5678, 1);
    check("tie1_cpu_data", {24'd0, cpu_data}, 32'h78);
    check("tie1_cpu_ok",   {31'd0, cpu_ok},   32'd1);

    // second tie: CPU was last, PCM again first
    cpu_addr = 15'h0030; pcm_addr = 18'h00043;
    serve("tie2_pcm_addr", 22'h000011, 16'hA55A, 0);
    check("tie2_pcm_data", {24'd0, pcm_data}, 32'hA5);
    serve("tie2_cpu_addr", CPU_OFS + 22'h18, 16'hC3D2, 0);
    check("tie2_cpu_data", {24'd0, cpu_data}, 32'hD2);

    // PCM address changes while waiting for data
    pcm_addr = 18'h00100;
    wait_req();
    check("chg_addr1", {10'd0, sdram_addr}, 32'h000070);
    do_ack(1);
    pcm_addr = 18'h00200;
    do_dok(16'h11AA);
    check("chg_ok_low", {31'd0, pcm_ok}, 32'd0);
    @(negedge clk);
    check("chg_req2",  {31'd0, sdram_req}, 32'd1);
    check("chg_addr2", {10'd0, sdram_addr}, 32'h0000F0);
    pcm_addr = 18'h00101;
    #1;
    check("chg_old_tag_ok",   {31'd0, pcm_ok},   32'd1);
    check("chg_old_tag_data", {24'd0, pcm_data}, 32'h11);
    pcm_addr = 18'h00200;
    #1;
    check("chg_new_ok_low", {31'd0, pcm_ok}, 32'd0);
    do_ack(1);
    do_dok(16'h3322);
    check("chg_ok",   {31'd0, pcm_ok},   32'd1);
    check("chg_data", {24'd0, pcm_data}, 32'h22);

    // download invalidates both caches and blocks requests
    check("dl_pre_cpu_ok", {31'd0, cpu_ok}, 32'd1);
    downloading = 1'b1;
    @(negedge clk);
    check("dl_cpu_ok", {31'd0, cpu_ok}, 32'd0);
    check("dl_pcm_ok", {31'd0, pcm_ok}, 32'd0);
    repeat (3) @(negedge clk);
    check("dl_noreq", {31'd0, sdram_req}, 32'd0);
    downloading = 1'b0;
    serve("dl_refetch_cpu", CPU_OFS + 22'h18, 16'hC3D2, 1);
    check("dl_cpu_data", {24'd0, cpu_data}, 32'hD2);
    serve("dl_refetch_pcm", 22'h0000F0, 16'h3322, 1);
    check("dl_pcm_ok", {31'd0, pcm_ok}, 32'd1);

    // reset while a fetch waits for data
    cpu_addr = 15'h0050;
    wait_req();
    check("rw_addr", {10'd0, sdram_addr}, CPU_OFS + 22'h28);
    do_ack(0);
    cpu_cs = 1'b0; pcm_cs = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    do_dok(16'h9999);
    check("rw_req",  {31'd0, sdram_req}, 32'd0);
    check("rw_data", {24'd0, cpu_data},  32'd0);
    cpu_cs = 1'b1;
    #1;
    check("rw_ok_low", {31'd0, cpu_ok}, 32'd0);
    @(negedge clk);
    serve("rw_fresh_addr", CPU_OFS + 22'h28, 16'h4321, 1);
    check("rw_fresh_ok",   {31'd0, cpu_ok},   32'd1);
    check("rw_fresh_data", {24'd0, cpu_data}, 32'h21);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
